// File: rtl/sm4_pkg.sv
// ============================================================================
// Module   : sm4_pkg
// Summary  : Shared SM4 constants, FSM encoding and linear transforms.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } sm4_state_e;

  // Data-path L: B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
  function automatic logic [31:0] sm4_l(input logic [31:0] b);
    return b
         ^ {b[29:0], b[31:30]}
         ^ {b[21:0], b[31:22]}
         ^ {b[13:0], b[31:14]}
         ^ {b[7:0],  b[31:8]};
  endfunction

  // Key-schedule L': B ^ B<<<13 ^ B<<<23
  function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
    return b
         ^ {b[18:0], b[31:19]}
         ^ {b[8:0],  b[31:9]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm4_round_engine_if.sv
// ============================================================================
// Module   : sm4_round_engine_if
// Summary  : Control, data and key-store signals of the SM4 round engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sm4_round_engine_if;

  logic         start;
  logic         dec;
  logic [127:0] din;
  logic [4:0]   rk_idx;
  logic [31:0]  rk;
  logic         busy;
  logic         finish;
  logic [127:0] dout;

  modport master (
    output start, dec, din, rk,
    input  rk_idx, busy, finish, dout
  );

  modport slave (
    input  start, dec, din, rk,
    output rk_idx, busy, finish, dout
  );

endinterface

`default_nettype wire

// File: rtl/sm4_round_engine_sbox.sv
// ============================================================================
// Module   : sm4_sbox
// Summary  : SM4 byte substitution box as a combinational lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm4_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [0:255][7:0] C_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign s_o = C_SBOX[a_i];

endmodule

`default_nettype wire

// File: rtl/sm4_round_engine_t_func.sv
// ============================================================================
// Module   : sm4_t_func
// Summary  : SM4 round function T = L(tau(A)), purely combinational.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm4_t_func
  import sm4_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] t_o
);

  logic [31:0] tau;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sm4_sbox u_sbox (
      .a_i (a_i[8*i +: 8]),
      .s_o (tau[8*i +: 8])
    );
  end

  assign t_o = sm4_l(tau);

endmodule

`default_nettype wire

// File: rtl/sm4_round_engine.sv
// ============================================================================
// Module   : sm4_round_engine
// Summary  : Iterative SM4 encrypt/decrypt datapath, one round per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS
) (
  input  logic                clk,
  input  logic                rst,
  sm4_round_engine_if.slave   bus
);

  sm4_state_e   state_q, state_d;
  logic [4:0]   rnd_q,   rnd_d;
  logic         dec_q,   dec_d;
  logic [127:0] x_q,     x_d;
  logic [127:0] dout_q,  dout_d;
  logic         finish_q, finish_d;

  logic [31:0]  t_in;
  logic [31:0]  t_out;
  logic [31:0]  x_new;
  logic         last_rnd;

  // x_q holds {X0, X1, X2, X3} with X0 in the top word.
  assign t_in     = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ bus.rk;
  assign x_new    = x_q[127:96] ^ t_out;
  assign last_rnd = (rnd_q == 5'(ROUNDS - 1));

  sm4_t_func u_t_func (
    .a_i (t_in),
    .t_o (t_out)
  );

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    dec_d    = dec_q;
    x_d      = x_q;
    dout_d   = dout_q;
    finish_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d     = bus.din;
          dec_d   = bus.dec;
          rnd_d   = 5'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        x_d   = {x_q[95:0], x_new};
        rnd_d = rnd_q + 5'd1;
        if (last_rnd) begin
          // Output is the reverse transform {X35, X34, X33, X32}.
          dout_d   = {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
          finish_d = 1'b1;
          rnd_d    = 5'd0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rnd_q    <= 5'd0;
      dec_q    <= 1'b0;
      x_q      <= '0;
      dout_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      dec_q    <= dec_d;
      x_q      <= x_d;
      dout_q   <= dout_d;
      finish_q <= finish_d;
    end
  end

  // Decryption walks the same key store backwards.
  assign bus.rk_idx = (state_q == ST_ROUND) ? (dec_q ? (5'd31 - rnd_q) : rnd_q) : 5'd0;
  assign bus.busy   = (state_q == ST_ROUND);
  assign bus.finish = finish_q;
  assign bus.dout   = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_sm4_round_engine.sv
// ============================================================================
// Module   : tb_sm4_round_engine
// Summary  : Directed and round-trip bench for the SM4 round engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sm4_round_engine;

  localparam logic [127:0] KEY_STD = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT_STD  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT_STD  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] rk_mem [32];

  sm4_round_engine_if bus ();

  sm4_round_engine #(.ROUNDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rk = rk_mem[bus.rk_idx];

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] ck;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32] ^ FK[i];
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i) * 7), 8'((4*i + 1) * 7), 8'((4*i + 2) * 7), 8'((4*i + 3) * 7)};
      b  = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      rk_mem[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk, input logic d);
    logic [31:0] x [36];
    logic [31:0] b;
    for (int i = 0; i < 4; i++) x[i] = blk[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk_mem[d ? 31 - i : i]);
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // Waits (bounded) for finish; start is dropped after the first edge. lat=-1 on timeout.
  task automatic wait_finish(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.finish === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dec = 1'b0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b want=0", bus.finish); end
    checks++; if (bus.dout !== '0)     begin errors++; $display("FAIL reset_dout got=%h want=0", bus.dout); end
    checks++; if (bus.rk_idx !== 5'd0) begin errors++; $display("FAIL reset_rk_idx got=%0d want=0", bus.rk_idx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    int lat;
    bus.dec = 1'b0; bus.din = PT_STD; bus.start = 1'b1;
    wait_finish(lat);
    checks++; if (lat !== 33)         begin errors++; $display("FAIL enc_latency got=%0d want=33", lat); end
    checks++; if (bus.dout !== CT_STD) begin errors++; $display("FAIL enc_dout got=%h want=%h", bus.dout, CT_STD); end
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL enc_busy_at_finish got=%b want=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.finish !== 1'b0) begin errors++; $display("FAIL enc_finish_pulse got=%b want=0", bus.finish); end
  endtask

  task automatic test_decrypt();
    int lat = -1;
    bus.dec = 1'b1; bus.din = CT_STD; bus.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.finish === 1'b1) begin
        lat = c;
        break;
      end
      checks++;
      if (bus.rk_idx !== 5'(32 - c) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL dec_rk_idx cycle=%0d got idx=%0d busy=%b want idx=%0d busy=1", c, bus.rk_idx, bus.busy, 32 - c);
      end
    end
    checks++; if (lat !== 33)          begin errors++; $display("FAIL dec_latency got=%0d want=33", lat); end
    checks++; if (bus.dout !== PT_STD) begin errors++; $display("FAIL dec_dout got=%h want=%h", bus.dout, PT_STD); end
    bus.dec = 1'b0;
  endtask

  task automatic test_ignore_start();
    int nfin = 0;
    int first_lat = -1;
    logic [127:0] fdout = '0;
    bus.dec = 1'b0; bus.din = PT_STD; bus.start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus.start = (c == 5 || c == 20);
      bus.din   = (c == 5 || c == 20) ? CT_STD : PT_STD;
      bus.dec   = (c == 5 || c == 20);
      if (bus.finish === 1'b1) begin
        nfin++;
        if (first_lat < 0) begin
          first_lat = c;
          fdout = bus.dout;
        end
      end
    end
    bus.start = 1'b0; bus.dec = 1'b0; bus.din = PT_STD;
    checks++; if (nfin !== 1)       begin errors++; $display("FAIL ignore_finish_count got=%0d want=1", nfin); end
    checks++; if (first_lat !== 33) begin errors++; $display("FAIL ignore_latency got=%0d want=33", first_lat); end
    checks++; if (fdout !== CT_STD) begin errors++; $display("FAIL ignore_dout got=%h want=%h", fdout, CT_STD); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat2 = -1;
    int holdbad = 0;
    bus.dec = 1'b0; bus.din = PT_STD; bus.start = 1'b1;
    wait_finish(lat);
    checks++; if (lat !== 33)          begin errors++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
    checks++; if (bus.dout !== CT_STD) begin errors++; $display("FAIL b2b_first_dout got=%h want=%h", bus.dout, CT_STD); end
    bus.dec = 1'b1; bus.din = CT_STD; bus.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.finish === 1'b1) begin
        lat2 = c;
        break;
      end
      if (bus.dout !== CT_STD) holdbad++;
    end
    checks++; if (lat2 !== 33)         begin errors++; $display("FAIL b2b_second_latency got=%0d want=33", lat2); end
    checks++; if (bus.dout !== PT_STD) begin errors++; $display("FAIL b2b_second_dout got=%h want=%h", bus.dout, PT_STD); end
    checks++; if (holdbad !== 0)       begin errors++; $display("FAIL b2b_dout_hold got=%0d changed cycles want=0", holdbad); end
    bus.dec = 1'b0;
  endtask

  task automatic test_abort();
    int nfin = 0;
    int lat;
    bus.dec = 1'b0; bus.din = PT_STD; bus.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++; if (bus.rk_idx !== 5'd10) begin errors++; $display("FAIL abort_round10_idx got=%0d want=10", bus.rk_idx); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.dout !== '0)     begin errors++; $display("FAIL abort_dout got=%h want=0", bus.dout); end
    checks++; if (bus.rk_idx !== 5'd0) begin errors++; $display("FAIL abort_rk_idx got=%0d want=0", bus.rk_idx); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.finish === 1'b1) nfin++;
    end
    checks++; if (nfin !== 0) begin errors++; $display("FAIL abort_no_finish got=%0d want=0", nfin); end
    bus.din = PT_STD; bus.start = 1'b1;
    wait_finish(lat);
    checks++; if (lat !== 33)          begin errors++; $display("FAIL abort_restart_latency got=%0d want=33", lat); end
    checks++; if (bus.dout !== CT_STD) begin errors++; $display("FAIL abort_restart_dout got=%h want=%h", bus.dout, CT_STD); end
  endtask

  task automatic test_random();
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int lat;
    for (int n = 0; n < 500; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      set_key(key);
      ct = model(pt, 1'b0);
      bus.dec = 1'b0; bus.din = pt; bus.start = 1'b1;
      wait_finish(lat);
      checks++;
      if (lat !== 33 || bus.dout !== ct) begin
        errors++;
        $display("FAIL rand_enc n=%0d got=%h lat=%0d want=%h lat=33", n, bus.dout, lat, ct);
      end
      bus.dec = 1'b1; bus.din = ct; bus.start = 1'b1;
      wait_finish(lat);
      checks++;
      if (lat !== 33 || bus.dout !== pt) begin
        errors++;
        $display("FAIL rand_dec n=%0d got=%h lat=%0d want=%h lat=33", n, bus.dout, lat, pt);
      end
    end
    bus.dec = 1'b0;
  endtask

  initial begin
    set_key(KEY_STD);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
